// File: rtl/hls_fu_pkg.sv
// ---------------------------------------------------------------------------
// hls_fu_pkg
// Shared definitions for the HLS functional-unit library.
//   HLS_ADD_RES_T(W) : adder result record {valid, overflow, cout, sum[W-1:0]}.
//                      It is a macro because its width follows each
//                      instance's WIDTH.
//   ADD_MAX_LATENCY  : deepest supported adder pipeline.
//   add_ovf()        : signed-overflow rule from the operand and result MSBs.
// ---------------------------------------------------------------------------
`ifndef HLS_FU_PKG_SV
`define HLS_FU_PKG_SV

`define HLS_ADD_RES_T(W) struct packed { logic valid; logic overflow; logic cout; logic [(W)-1:0] sum; }

package hls_fu_pkg;

  localparam int ADD_MAX_LATENCY = 4;

  // Signed overflow: both operands share a sign and the result sign differs.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

`endif

// File: rtl/add_fu_stage.sv
// ---------------------------------------------------------------------------
// add_fu_stage
// One pipeline stage of the adder: an enabled register that holds a result
// record, with a synchronous clear.
//   clk  : rising-edge clock
//   rst  : synchronous, active-high clear (takes priority over i_en)
//   i_en : 1 = load i_d, 0 = hold
//   i_d  : record from the previous stage
//   o_q  : registered record
// ---------------------------------------------------------------------------
module add_fu_stage
  import hls_fu_pkg::*;
#(
  parameter type res_t = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  res_t i_d,
  output res_t o_q
);

  res_t r_q;

  // Stage register: clear on reset, load on enable, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/add_fu.sv
// ---------------------------------------------------------------------------
// add_fu
// Integer adder functional unit for HLS datapaths: in0 + in1 + cin, with
// carry-out and signed-overflow flags, and an optional pipeline of LATENCY
// register stages.
// Parameters:
//   WIDTH   : operand/result width (>= 1)
//   LATENCY : number of register stages, 0..ADD_MAX_LATENCY
//             (0 = purely combinational)
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//                     (both unused when LATENCY = 0)
//   i_en            : pipeline advance; 0 stalls every stage
//   i_in_valid      : operands valid this cycle
//   i_in0, i_in1    : operands
//   i_cin           : carry-in
//   o_out           : sum[WIDTH-1:0]
//   o_cout          : unsigned carry-out
//   o_overflow      : signed overflow
//   o_out_valid     : outputs valid this cycle
// ---------------------------------------------------------------------------
module add_fu
  import hls_fu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_in_valid,
  input  logic [WIDTH-1:0] i_in0,
  input  logic [WIDTH-1:0] i_in1,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_out,
  output logic             o_cout,
  output logic             o_overflow,
  output logic             o_out_valid
);

  typedef `HLS_ADD_RES_T(WIDTH) add_res_t;

  if ((LATENCY < 0) || (LATENCY > ADD_MAX_LATENCY)) begin : g_bad_latency
    $error("add_fu: LATENCY must be within 0..%0d", ADD_MAX_LATENCY);
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("add_fu: WIDTH must be at least 1");
  end

  logic [WIDTH:0] w_sum;
  add_res_t       w_res;
  add_res_t       w_out;

  // Fresh result at the input side; the data is formed even when not valid.
  always_comb begin
    w_sum          = {1'b0, i_in0} + {1'b0, i_in1} + {{WIDTH{1'b0}}, i_cin};
    w_res.valid    = i_in_valid;
    w_res.sum      = w_sum[WIDTH-1:0];
    w_res.cout     = w_sum[WIDTH];
    w_res.overflow = add_ovf(i_in0[WIDTH-1], i_in1[WIDTH-1], w_sum[WIDTH-1]);
  end

  if (LATENCY == 0) begin : g_comb
    // Combinational unit: clock, reset and enable play no part.
    logic w_unused_ok;
    assign w_unused_ok = clk ^ rst ^ i_en;
    assign w_out       = w_res;
  end else begin : g_pipe
    add_res_t w_stage [LATENCY+1];
    assign w_stage[0] = w_res;
    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_st
      add_fu_stage #(
        .res_t (add_res_t)
      ) u_stage (
        .clk  (clk),
        .rst  (rst),
        .i_en (i_en),
        .i_d  (w_stage[gi]),
        .o_q  (w_stage[gi+1])
      );
    end
    assign w_out = w_stage[LATENCY];
  end

  assign o_out       = w_out.sum;
  assign o_cout      = w_out.cout;
  assign o_overflow  = w_out.overflow;
  assign o_out_valid = w_out.valid;

endmodule

// File: tb/tb_add_fu.sv
`timescale 1ns/1ps
module tb_add_fu;

  logic        clk = 1'b0;
  logic        rst, en, in_valid, cin;
  logic [31:0] in0, in1;
  logic [31:0] exp_out;
  logic        exp_cout, exp_ovf;
  int          checks = 0;
  int          errors = 0;
  bit          done   = 1'b0;

  always #5 clk = ~clk;

  // Directed vectors with hand-computed results {sum, cout, overflow}.
  logic [31:0] t_a [10] = '{32'h5, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h3, 32'h80000000,
                            32'hFFFFFFFF, 32'h0, 32'h12345678, 32'h7FFFFFFF, 32'h80000000};
  logic [31:0] t_b [10] = '{32'h7, 32'h1, 32'h1, 32'h4, 32'h80000000,
                            32'hFFFFFFFF, 32'h0, 32'h11111111, 32'h7FFFFFFF, 32'hFFFFFFFF};
  logic        t_c [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] t_s [10] = '{32'hC, 32'h0, 32'h80000000, 32'h8, 32'h0,
                            32'hFFFFFFFF, 32'h0, 32'h23456789, 32'hFFFFFFFF, 32'h7FFFFFFF};
  logic        t_co[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic        t_ov[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  // Reference models: {overflow, cout, sum}; overflow from a true signed range test.
  function automatic logic [33:0] model32(input logic [31:0] a, input logic [31:0] b, input logic c);
    longint unsigned u;
    longint          s;
    u = longint'(a) + longint'(b) + longint'(c);
    s = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
    return {(s > 64'sd2147483647) || (s < -64'sd2147483648), u[32], u[31:0]};
  endfunction

  function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int u;
    int s;
    u = int'(a) + int'(b) + int'(c);
    s = int'($signed(a)) + int'($signed(b)) + int'(c);
    return {(s > 127) || (s < -128), u[8], u[7:0]};
  endfunction

  // Combinational instances (W=32 and W=8).
  logic [31:0] z_out;
  logic        z_c, z_v, z_vld;
  logic [7:0]  b_out;
  logic        b_c, b_v, b_vld;

  add_fu #(.WIDTH(32), .LATENCY(0)) u_l0_w32 (
    .clk(clk), .rst(rst), .i_en(en), .i_in_valid(in_valid), .i_in0(in0), .i_in1(in1),
    .i_cin(cin), .o_out(z_out), .o_cout(z_c), .o_overflow(z_v), .o_out_valid(z_vld));

  add_fu #(.WIDTH(8), .LATENCY(0)) u_l0_w8 (
    .clk(clk), .rst(rst), .i_en(en), .i_in_valid(in_valid), .i_in0(in0[7:0]), .i_in1(in1[7:0]),
    .i_cin(cin), .o_out(b_out), .o_cout(b_c), .o_overflow(b_v), .o_out_valid(b_vld));

  // Pipelined instances L=1..3, each with its own scoreboard and monitor.
  for (genvar L = 1; L <= 3; L++) begin : g_pipe
    typedef struct packed { int tag; logic [31:0] s; logic c; logic v; } exp_t;
    logic [31:0] o_out;
    logic        o_cout, o_ovf, o_vld;
    exp_t        q[$];
    exp_t        e;
    int          adv      = 0;
    bit          last_rst = 1'b0;
    bit          last_en  = 1'b0;
    bit          armed    = 1'b0;
    logic [34:0] snap;

    add_fu #(.WIDTH(32), .LATENCY(L)) u_dut (
      .clk(clk), .rst(rst), .i_en(en), .i_in_valid(in_valid), .i_in0(in0), .i_in1(in1),
      .i_cin(cin), .o_out(o_out), .o_cout(o_cout), .o_overflow(o_ovf), .o_out_valid(o_vld));

    // Scoreboard push: an accepted operand pair is due after L advancing edges.
    initial forever begin
      @(posedge clk);
      last_rst = rst;
      last_en  = en;
      if (rst) begin
        q.delete();
        armed = 1'b1;
      end else if (en) begin
        adv++;
        if (in_valid) q.push_back('{adv + L - 1, exp_out, exp_cout, exp_ovf});
      end
    end

    // Monitor: reset zeros, frozen stall outputs, in-order results at exact latency.
    initial forever begin
      @(negedge clk);
      if (armed && !done) begin
        if (last_rst) begin
          checks++;
          if ({o_out, o_cout, o_ovf, o_vld} !== 35'd0) begin
            errors++;
            $display("FAIL reset_L%0d got=%h want=0", L, {o_out, o_cout, o_ovf, o_vld});
          end
        end else if (!last_en) begin
          checks++;
          if ({o_out, o_cout, o_ovf, o_vld} !== snap) begin
            errors++;
            $display("FAIL stall_hold_L%0d got=%h want=%h", L, {o_out, o_cout, o_ovf, o_vld}, snap);
          end
        end else if (o_vld === 1'b1) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid_L%0d got out=%h want no valid", L, o_out);
          end else begin
            e = q.pop_front();
            if ({o_out, o_cout, o_ovf} !== {e.s, e.c, e.v} || adv != e.tag) begin
              errors++;
              $display("FAIL result_L%0d got out=%h cout=%b ovf=%b at=%0d want out=%h cout=%b ovf=%b at=%0d",
                       L, o_out, o_cout, o_ovf, adv, e.s, e.c, e.v, e.tag);
            end
          end
        end else if (o_vld !== 1'b0) begin
          checks++;
          errors++;
          $display("FAIL valid_known_L%0d got=%b want=0", L, o_vld);
        end
        snap = {o_out, o_cout, o_ovf, o_vld};
      end
    end

    // Every accepted operand pair must have come out by the end of the drain.
    initial begin
      wait (done);
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL drain_L%0d got=%0d pending want=0", L, q.size());
      end
    end
  end

  task automatic check_l0(input logic [31:0] a, input logic [31:0] b, input logic c, input logic v);
    logic [9:0] m8;
    m8 = model8(a[7:0], b[7:0], c);
    checks++;
    if ({z_out, z_c, z_v, z_vld} !== {exp_out, exp_cout, exp_ovf, v}) begin
      errors++;
      $display("FAIL l0_w32 got=%h/%b/%b/%b want=%h/%b/%b/%b",
               z_out, z_c, z_v, z_vld, exp_out, exp_cout, exp_ovf, v);
    end
    checks++;
    if ({b_out, b_c, b_v, b_vld} !== {m8[7:0], m8[8], m8[9], v}) begin
      errors++;
      $display("FAIL l0_w8 got=%h/%b/%b/%b want=%h/%b/%b/%b",
               b_out, b_c, b_v, b_vld, m8[7:0], m8[8], m8[9], v);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic c, input logic v,
                       input logic e, input logic r,
                       input logic [31:0] xo, input logic xc, input logic xv);
    @(posedge clk);
    #2;
    in0 = a; in1 = b; cin = c; in_valid = v; en = e; rst = r;
    exp_out = xo; exp_cout = xc; exp_ovf = xv;
    #1;
    check_l0(a, b, c, v);
  endtask

  task automatic drive_rand(input logic v, input logic e, input logic r);
    logic [31:0] a, b;
    logic        c;
    logic [33:0] m;
    a = $urandom();
    b = $urandom();
    c = 1'($urandom_range(0, 1));
    m = model32(a, b, c);
    drive(a, b, c, v, e, r, m[31:0], m[32], m[33]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; cin = 1'b0; in0 = 32'h0; in1 = 32'h0;
    exp_out = 32'h0; exp_cout = 1'b0; exp_ovf = 1'b0;
    for (int i = 0; i < 3; i++) drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
    idle(2);
    // Directed vectors back-to-back, then again with a gapped valid pattern.
    for (int i = 0; i < 10; i++)
      drive(t_a[i], t_b[i], t_c[i], 1'b1, 1'b1, 1'b0, t_s[i], t_co[i], t_ov[i]);
    for (int i = 0; i < 10; i++)
      drive(t_a[i], t_b[i], t_c[i], 1'((i % 3) != 1), 1'b1, 1'b0, t_s[i], t_co[i], t_ov[i]);
    // Stall for 4 cycles mid-stream while the inputs keep changing.
    for (int i = 0; i < 3; i++) drive_rand(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive_rand(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive_rand(1'b1, 1'b1, 1'b0);
    // Reset with results in flight, then a fresh operand after a quiet period.
    for (int i = 0; i < 2; i++) drive_rand(1'b1, 1'b1, 1'b0);
    drive_rand(1'b1, 1'b1, 1'b1);
    idle(5);
    drive(t_a[0], t_b[0], t_c[0], 1'b1, 1'b1, 1'b0, t_s[0], t_co[0], t_ov[0]);
    idle(4);
    // Reset must win over a stall.
    for (int i = 0; i < 2; i++) drive_rand(1'b1, 1'b1, 1'b0);
    drive_rand(1'b1, 1'b0, 1'b1);
    idle(5);
    // Random traffic with random valid and enable.
    for (int i = 0; i < 1000; i++)
      drive_rand(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0), 1'b0);
    idle(6);
    @(posedge clk);
    done = 1'b1;
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
